// File: rtl/uart_tx_cfg_if.sv
// Parallel-side bundle for uart_tx_cfg: word, framing config,
// handshake and the serial line.
interface uart_tx_cfg_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  Stop2;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  TX_Ready;
  logic                  busy;
  logic                  TX_OUT;

  modport master (
    output P_DATA, Data_Valid, PAR_EN,
    output PAR_TYP, Stop2, Prescale,
    input  TX_Ready, busy, TX_OUT
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN,
    input  PAR_TYP, Stop2, Prescale,
    output TX_Ready, busy, TX_OUT
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter with internal baud divider.
// Define UART_TX_HOLD_BUF_EN for a one-word holding buffer.
module uart_tx_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input logic          clk,
  input logic          rst,
  uart_tx_cfg_if.slave bus
);
  localparam int IW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_e;

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [PRESCALE_W-1:0] ps_q, ps_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  pen_q, pen_d;
  logic                  par_q, par_d;
  logic                  s2_q, s2_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic                  ready, accept, load;
  logic                  tc, last_data, last_stop;
  logic [PRESCALE_W-1:0] in_ps, ld_ps;
  logic                  in_par, ld_par;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_pen, ld_s2;

  assign in_ps     = (bus.Prescale == '0) ?
                     PRESCALE_W'(1) : bus.Prescale;
  assign in_par    = (^bus.P_DATA) ^ bus.PAR_TYP;
  assign tc        = (cnt_q == ps_q - PRESCALE_W'(1));
  assign last_data = (idx_q == IW'(DATA_WIDTH - 1));
  assign last_stop = (idx_q == IW'(s2_q));
  assign accept    = bus.Data_Valid & ready;

`ifdef UART_TX_HOLD_BUF_EN
  logic                  use_buf;
  logic                  b_full_q;
  logic [DATA_WIDTH-1:0] b_data_q;
  logic                  b_pen_q, b_par_q, b_s2_q;
  logic [PRESCALE_W-1:0] b_ps_q;

  assign ready   = ~rst & ~b_full_q;
  assign ld_data = use_buf ? b_data_q : bus.P_DATA;
  assign ld_pen  = use_buf ? b_pen_q  : bus.PAR_EN;
  assign ld_par  = use_buf ? b_par_q  : in_par;
  assign ld_s2   = use_buf ? b_s2_q   : bus.Stop2;
  assign ld_ps   = use_buf ? b_ps_q   : in_ps;

  // Words arriving while a frame is running wait here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_full_q <= 1'b0;
      b_data_q <= '0;
      b_pen_q  <= 1'b0;
      b_par_q  <= 1'b0;
      b_s2_q   <= 1'b0;
      b_ps_q   <= PRESCALE_W'(1);
    end else begin
      if (use_buf) b_full_q <= 1'b0;
      if (accept && state_q != IDLE) begin
        b_full_q <= 1'b1;
        b_data_q <= bus.P_DATA;
        b_pen_q  <= bus.PAR_EN;
        b_par_q  <= in_par;
        b_s2_q   <= bus.Stop2;
        b_ps_q   <= in_ps;
      end
    end
  end
`else
  assign ready   = ~rst & (state_q == IDLE) & ~busy_q;
  assign ld_data = bus.P_DATA;
  assign ld_pen  = bus.PAR_EN;
  assign ld_par  = in_par;
  assign ld_s2   = bus.Stop2;
  assign ld_ps   = in_ps;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ps_q    <= PRESCALE_W'(1);
      idx_q   <= '0;
      sh_q    <= '0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
      s2_q    <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ps_q    <= ps_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      pen_q   <= pen_d;
      par_q   <= par_d;
      s2_q    <= s2_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ps_d    = ps_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    pen_d   = pen_q;
    par_d   = par_q;
    s2_d    = s2_q;
    load    = 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
    use_buf = 1'b0;
`endif
    if (state_q != IDLE)
      cnt_d = tc ? '0 : cnt_q + PRESCALE_W'(1);
    unique case (state_q)
      IDLE: begin
`ifdef UART_TX_HOLD_BUF_EN
        if (b_full_q) begin
          load    = 1'b1;
          use_buf = 1'b1;
        end else if (accept) begin
          load = 1'b1;
        end
`else
        if (accept) load = 1'b1;
`endif
      end
      START: if (tc) state_d = DATA;
      DATA: begin
        if (tc) begin
          sh_d = sh_q >> 1;
          if (last_data) begin
            idx_d   = '0;
            state_d = pen_q ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      PARITY: if (tc) state_d = STOP;
      STOP: begin
        if (tc) begin
          if (last_stop) begin
            idx_d   = '0;
            state_d = IDLE;
`ifdef UART_TX_HOLD_BUF_EN
            if (b_full_q) begin
              load    = 1'b1;
              use_buf = 1'b1;
            end
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = START;
      cnt_d   = '0;
      idx_d   = '0;
      sh_d    = ld_data;
      pen_d   = ld_pen;
      par_d   = ld_par;
      s2_d    = ld_s2;
      ps_d    = ld_ps;
    end
  end

  // Line level and busy are registered one edge behind the state
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_q != IDLE);
    unique case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_q[0];
      PARITY:  tx_d = par_q;
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.TX_OUT   = tx_q;
  assign bus.busy     = busy_q;
  assign bus.TX_Ready = ready;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg (DATA_WIDTH=8, PRESCALE_W=6).
// Frames are hand-written bit vectors, first bit on the line at index 0.
module tb_uart_tx_cfg;
  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  uart_tx_cfg_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) bus ();

  uart_tx_cfg #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d, input logic pe,
                     input logic pt, input logic s2,
                     input logic [5:0] ps);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Stop2      = s2;
    bus.Prescale   = ps;
    bus.Data_Valid = 1'b1;
    tick();
    bus.Data_Valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.Data_Valid = 1'b0;
    bus.P_DATA = '0;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    bus.Stop2 = 1'b0;
    bus.Prescale = 6'd1;
    #1 rst = 1'b1;
    #2;
    total_cnt++;
    if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0 ||
        bus.TX_Ready !== 1'b0)
      $display("FAIL rst_hold: tx=%b busy=%b rdy=%b want 1 0 0",
               bus.TX_OUT, bus.busy, bus.TX_Ready);
    else pass_cnt++;
    tick();
    tick();
    rst = 1'b0;
    #1;
    total_cnt++;
    if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0 ||
        bus.TX_Ready !== 1'b1)
      $display("FAIL rst_rel: tx=%b busy=%b rdy=%b want 1 0 1",
               bus.TX_OUT, bus.busy, bus.TX_Ready);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_parity_even();
    logic [0:10] e;
    e = 11'b0_1_0000000_1_1;
    put(8'h01, 1'b1, 1'b0, 1'b0, 6'd1);
    for (int j = 0; j < 11; j++) begin
      tick();
      total_cnt++;
      if (bus.TX_OUT !== e[j] || bus.busy !== 1'b1)
        $display("FAIL t1 bit%0d: tx=%b busy=%b want %b 1",
                 j, bus.TX_OUT, bus.busy, e[j]);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL t1 end: tx=%b busy=%b want 1 0",
               bus.TX_OUT, bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_odd_stop2();
    logic [0:11] e;
    e = 12'b0_10100101_1_11;
    put(8'hA5, 1'b1, 1'b1, 1'b1, 6'd4);
    for (int j = 0; j < 12; j++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        total_cnt++;
        if (bus.TX_OUT !== e[j] || bus.busy !== 1'b1)
          $display("FAIL t2 bit%0d c%0d: tx=%b busy=%b want %b 1",
                   j, c, bus.TX_OUT, bus.busy, e[j]);
        else pass_cnt++;
      end
    end
    tick();
    total_cnt++;
    if (bus.busy !== 1'b0)
      $display("FAIL t2 end: busy=%b want 0", bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_cfg_change();
    logic [0:9] e;
    e = 10'b0_11000111_1;
    put(8'hE3, 1'b0, 1'b0, 1'b0, 6'd2);
    for (int j = 0; j < 10; j++) begin
      for (int c = 0; c < 2; c++) begin
        tick();
        total_cnt++;
        if (bus.TX_OUT !== e[j] || bus.busy !== 1'b1)
          $display("FAIL t3 bit%0d c%0d: tx=%b busy=%b want %b 1",
                   j, c, bus.TX_OUT, bus.busy, e[j]);
        else pass_cnt++;
        if (j == 3 && c == 0) begin
          bus.P_DATA   = 8'h00;
          bus.PAR_EN   = 1'b1;
          bus.Stop2    = 1'b1;
          bus.Prescale = 6'd5;
        end
      end
    end
    tick();
    total_cnt++;
    if (bus.busy !== 1'b0)
      $display("FAIL t3 end: busy=%b want 0", bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [0:9] e1;
    logic [0:9] e2;
    logic       rdy_exp;
    e1 = 10'b0_10101010_1;
    e2 = 10'b0_11110000_1;
`ifdef UART_TX_HOLD_BUF_EN
    rdy_exp = 1'b1;
`else
    rdy_exp = 1'b0;
`endif
    put(8'h55, 1'b0, 1'b0, 1'b0, 6'd1);
    for (int j = 0; j < 10; j++) begin
      tick();
      total_cnt++;
      if (bus.TX_OUT !== e1[j] || bus.busy !== 1'b1)
        $display("FAIL t4a bit%0d: tx=%b busy=%b want %b 1",
                 j, bus.TX_OUT, bus.busy, e1[j]);
      else pass_cnt++;
      if (j == 1) begin
        total_cnt++;
        if (bus.TX_Ready !== rdy_exp)
          $display("FAIL t4 rdy: got %b want %b",
                   bus.TX_Ready, rdy_exp);
        else pass_cnt++;
        bus.P_DATA     = 8'h0F;
        bus.Data_Valid = 1'b1;
      end
      if (j == 2) bus.Data_Valid = 1'b0;
    end
`ifdef UART_TX_HOLD_BUF_EN
    for (int j = 0; j < 10; j++) begin
      tick();
      total_cnt++;
      if (bus.TX_OUT !== e2[j] || bus.busy !== 1'b1)
        $display("FAIL t4b bit%0d: tx=%b busy=%b want %b 1",
                 j, bus.TX_OUT, bus.busy, e2[j]);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (bus.busy !== 1'b0)
      $display("FAIL t4b end: busy=%b want 0", bus.busy);
    else pass_cnt++;
`else
    for (int j = 0; j < 12; j++) begin
      tick();
      total_cnt++;
      if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0)
        $display("FAIL t4 drop c%0d: tx=%b busy=%b want 1 0 (%b)",
                 j, bus.TX_OUT, bus.busy, e2[0]);
      else pass_cnt++;
    end
`endif
  endtask

  task automatic test_reset_abort();
    logic [0:9] e;
    e = 10'b0_10000001_1;
    put(8'h0F, 1'b0, 1'b0, 1'b0, 6'd3);
    repeat (17) tick();
    total_cnt++;
    if (bus.TX_OUT !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL t5 pre: tx=%b busy=%b want 0 1",
               bus.TX_OUT, bus.busy);
    else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    total_cnt++;
    if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0 ||
        bus.TX_Ready !== 1'b0)
      $display("FAIL t5 abort: tx=%b busy=%b rdy=%b want 1 0 0",
               bus.TX_OUT, bus.busy, bus.TX_Ready);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
    put(8'h81, 1'b0, 1'b0, 1'b0, 6'd3);
    for (int j = 0; j < 10; j++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        total_cnt++;
        if (bus.TX_OUT !== e[j] || bus.busy !== 1'b1)
          $display("FAIL t5 bit%0d c%0d: tx=%b busy=%b want %b 1",
                   j, c, bus.TX_OUT, bus.busy, e[j]);
        else pass_cnt++;
      end
    end
    tick();
    total_cnt++;
    if (bus.busy !== 1'b0)
      $display("FAIL t5 end: busy=%b want 0", bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_prescale_zero();
    logic [0:9] e;
    e = 10'b0_11111111_1;
    put(8'hFF, 1'b0, 1'b0, 1'b0, 6'd0);
    for (int j = 0; j < 10; j++) begin
      tick();
      total_cnt++;
      if (bus.TX_OUT !== e[j] || bus.busy !== 1'b1)
        $display("FAIL t6 bit%0d: tx=%b busy=%b want %b 1",
                 j, bus.TX_OUT, bus.busy, e[j]);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (bus.busy !== 1'b0)
      $display("FAIL t6 end: busy=%b want 0", bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_prescale_max();
    logic [0:9] e;
    e = 10'b0_10000000_1;
    put(8'h01, 1'b0, 1'b0, 1'b0, 6'd63);
    for (int j = 0; j < 10; j++) begin
      for (int c = 0; c < 63; c++) begin
        tick();
        total_cnt++;
        if (bus.TX_OUT !== e[j] || bus.busy !== 1'b1)
          $display("FAIL t7 bit%0d c%0d: tx=%b busy=%b want %b 1",
                   j, c, bus.TX_OUT, bus.busy, e[j]);
        else pass_cnt++;
      end
    end
    tick();
    total_cnt++;
    if (bus.busy !== 1'b0)
      $display("FAIL t7 end: busy=%b want 0", bus.busy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_parity_even();
    test_odd_stop2();
    test_cfg_change();
    test_back_to_back();
    test_reset_abort();
    test_prescale_zero();
    test_prescale_max();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
